// File: rtl/addr8u_pkg.sv
// Shared types and helpers for the 8-bit adder feed-and-check stage.
// Holds the FSM state encoding, datapath widths and the behavioural golden sum.
package addr8u_pkg;

  localparam int ADDR_W = 8;
  localparam int SUM_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Reference sum the adder result is judged against; the carry lands in bit 8.
  function automatic logic [SUM_W-1:0] golden_sum(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/addr8u_check_stage_if.sv
// Operand/result handshake bundle of the adder check stage.
// master = producer/consumer side, slave = the stage itself.
interface addr8u_check_stage_if;
  import addr8u_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_a;
  logic [ADDR_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic              out_err;
  logic [1:0]        out_retry;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_err, out_retry
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_err, out_retry
  );

endinterface

// File: rtl/addr8u_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module addr8u_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count events, sticking at all-ones until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (clr_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/addr8u_check_stage.sv
// Feeds registered operands to an external combinational adder, checks its result
// against a golden sum, re-issues on mismatch and flags sums it had to correct.
module addr8u_check_stage
  import addr8u_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_RETRY = 1,
  parameter int SETTLE    = 1
) (
  input  logic              clk,
  input  logic              rst,
  addr8u_check_stage_if.slave bus,
  output logic [ADDR_W-1:0] add_a,
  output logic [ADDR_W-1:0] add_b,
  input  logic [SUM_W-1:0]  add_o,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              clr_cnt
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);
  localparam state_e     ST_ISSUE  = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;

  state_e            state_q;
  logic [ADDR_W-1:0] add_a_q;
  logic [ADDR_W-1:0] add_b_q;
  logic [3:0]        settle_q;
  logic [1:0]        retry_q;
  logic [SUM_W-1:0]  out_sum_q;
  logic              out_err_q;
  logic              out_valid_q;
  logic              in_ready_q;

  logic [SUM_W-1:0]  golden_d;
  logic              mismatch_d;

  assign golden_d   = golden_sum(add_a_q, add_b_q);
  assign mismatch_d = (state_q == ST_CHECK) && (add_o != golden_d);

  // Whole handshake/retry sequencer. DONE spends one cycle presenting the
  // registered result before out_valid rises, so the result is stable first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      add_a_q     <= {ADDR_W{1'b0}};
      add_b_q     <= {ADDR_W{1'b0}};
      settle_q    <= 4'd0;
      retry_q     <= 2'd0;
      out_sum_q   <= {SUM_W{1'b0}};
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            add_a_q    <= bus.in_a;
            add_b_q    <= bus.in_b;
            retry_q    <= 2'd0;
            settle_q   <= SETTLE_LD;
            in_ready_q <= 1'b0;
            state_q    <= ST_ISSUE;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          settle_q <= settle_q - 4'd1;
          if (settle_q == 4'd1) begin
            state_q <= ST_CHECK;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_CHECK: begin
          if (!mismatch_d) begin
            out_sum_q <= add_o;
            out_err_q <= 1'b0;
            state_q   <= ST_DONE;
          end else if (retry_q < RETRY_MAX) begin
            retry_q  <= retry_q + 2'd1;
            settle_q <= SETTLE_LD;
            state_q  <= ST_ISSUE;
          end else begin
            out_sum_q <= golden_d;
            out_err_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  addr8u_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (mismatch_d),
    .cnt_o (err_cnt)
  );

  assign add_a         = add_a_q;
  assign add_b         = add_b_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_retry = retry_q;

endmodule
